// File: rtl/switch_byte_entry.sv
// switch_byte_entry
//
// Debounces the four board push-switches, lets the operator compose an 8-bit
// value one nibble at a time, and hands a submitted byte to the CPU input port
// through a valid/ack handshake.
//
// Parameters:
//   DEBOUNCE_LIMIT  cycles a synchronized level must differ from the stable
//                   value before the stable value flips (>= 2)
// Ports:
//   i_Clk       board clock, rising edge
//   i_Reset     synchronous active-high reset
//   i_Switch    raw switch levels: [0] high nibble +1, [1] low nibble +1,
//               [2] submit, [3] clear entry
//   i_In_Ack    CPU consumed o_In_Data (pulse or level)
//   o_Entry     byte being composed, for the display
//   o_In_Data   last submitted byte, frozen while o_In_Valid is high
//   o_In_Valid  submitted byte awaiting ack
//   o_Press     one-cycle press pulse per switch
module switch_byte_entry #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Switch,
    input  logic       i_In_Ack,
    output logic [7:0] o_Entry,
    output logic [7:0] o_In_Data,
    output logic       o_In_Valid,
    output logic [3:0] o_Press
);

    localparam int unsigned CntW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {
        StIdle,
        StPending
    } state_t;

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_stable;
    logic [3:0]      r_stable_d;
    logic [3:0]      r_press;
    logic [CntW-1:0] r_cnt [4];
    logic [7:0]      r_entry;
    logic [7:0]      r_in_data;
    state_t          r_state;

    logic [7:0]      w_entry_next;
    state_t          w_state_next;
    logic            w_load;

    // Two-flop synchronizer, then per-switch debounce counter.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CntMax) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end
            end
        end
    end

    // Press pulse lands the cycle after stable rises; releases are ignored.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_stable_d <= '0;
            r_press    <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    // Nibble increments wrap within their nibble; clear overrides both.
    always_comb begin
        w_entry_next = r_entry;
        if (r_press[3]) begin
            w_entry_next = '0;
        end else begin
            if (r_press[0]) begin
                w_entry_next[7:4] = r_entry[7:4] + 4'd1;
            end
            if (r_press[1]) begin
                w_entry_next[3:0] = r_entry[3:0] + 4'd1;
            end
        end
    end

    // Submit is only taken in idle; in pending it is dropped, not queued.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_press[2]) begin
                    w_load       = 1'b1;
                    w_state_next = StPending;
                end
            end
            StPending: begin
                if (i_In_Ack) begin
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state   <= StIdle;
            r_entry   <= '0;
            r_in_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_entry <= w_entry_next;
            // Captures the entry as it stood before any same-cycle edit.
            if (w_load) begin
                r_in_data <= r_entry;
            end
        end
    end

    assign o_Entry    = r_entry;
    assign o_In_Data  = r_in_data;
    assign o_In_Valid = (r_state == StPending);
    assign o_Press    = r_press;

endmodule

// File: tb/tb_switch_byte_entry.sv
// tb_switch_byte_entry
//
// Directed bench for switch_byte_entry with DEBOUNCE_LIMIT = 4. Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_switch_byte_entry;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       ack;
    logic [7:0] entry;
    logic [7:0] in_data;
    logic       in_valid;
    logic [3:0] press;

    int n_cmp;
    int n_fail;

    switch_byte_entry #(
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (rst),
        .i_Switch  (sw),
        .i_In_Ack  (ack),
        .o_Entry   (entry),
        .o_In_Data (in_data),
        .o_In_Valid(in_valid),
        .o_Press   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the switches long enough to register, then release and settle.
    task automatic press_sw(input logic [3:0] m);
        sw = m;
        repeat (10) tick();
        sw = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        ack = 1'b0;
        repeat (3) tick();
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL reset_entry got %h want 00", entry); end
        n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", in_data); end
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", in_valid); end
        n_cmp++; if (press !== 4'b0000) begin n_fail++; $display("FAIL reset_press got %b want 0000", press); end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL post_reset_entry got %h want 00", entry); end
    endtask

    task automatic test_debounce();
        logic [3:0] exp_p;
        logic [7:0] exp_e;
        sw = 4'b0010;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_p = (k == 7) ? 4'b0010 : 4'b0000;
            exp_e = (k >= 8) ? 8'h01 : 8'h00;
            n_cmp++; if (press !== exp_p) begin n_fail++; $display("FAIL latency_press k=%0d got %b want %b", k, press, exp_p); end
            n_cmp++; if (entry !== exp_e) begin n_fail++; $display("FAIL latency_entry k=%0d got %h want %h", k, entry, exp_e); end
        end
        sw = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++; if (press !== 4'b0000) begin n_fail++; $display("FAIL release_press k=%0d got %b want 0000", k, press); end
        end
        n_cmp++; if (entry !== 8'h01) begin n_fail++; $display("FAIL release_entry got %h want 01", entry); end
        // Three-cycle glitch must be filtered out.
        sw = 4'b0001;
        repeat (3) tick();
        sw = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++; if (press !== 4'b0000) begin n_fail++; $display("FAIL glitch_press k=%0d got %b want 0000", k, press); end
        end
        n_cmp++; if (entry !== 8'h01) begin n_fail++; $display("FAIL glitch_entry got %h want 01", entry); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_e;
        press_sw(4'b1000);
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL wrap_clear got %h want 00", entry); end
        for (int i = 0; i < 16; i++) begin
            press_sw(4'b0001);
            exp_e = 8'((i + 1) << 4);
            n_cmp++; if (entry !== exp_e) begin n_fail++; $display("FAIL wrap_high i=%0d got %h want %h", i, entry, exp_e); end
        end
        for (int i = 0; i < 17; i++) begin
            press_sw(4'b0010);
            exp_e = {4'h0, 4'(i + 1)};
            n_cmp++; if (entry !== exp_e) begin n_fail++; $display("FAIL wrap_low i=%0d got %h want %h", i, entry, exp_e); end
        end
    endtask

    task automatic test_handshake();
        press_sw(4'b1000);
        repeat (3) press_sw(4'b0001);
        repeat (10) press_sw(4'b0010);
        n_cmp++; if (entry !== 8'h3A) begin n_fail++; $display("FAIL hs_entry got %h want 3a", entry); end
        press_sw(4'b0100);
        n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid1 got %b want 1", in_valid); end
        n_cmp++; if (in_data !== 8'h3A) begin n_fail++; $display("FAIL hs_data1 got %h want 3a", in_data); end
        press_sw(4'b0001);
        press_sw(4'b0010);
        n_cmp++; if (entry !== 8'h4B) begin n_fail++; $display("FAIL hs_edit got %h want 4b", entry); end
        press_sw(4'b0100);
        n_cmp++; if (in_data !== 8'h3A) begin n_fail++; $display("FAIL hs_frozen got %h want 3a", in_data); end
        n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL hs_still_valid got %b want 1", in_valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL hs_ack got %b want 0", in_valid); end
        tick();
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL hs_no_requeue got %b want 0", in_valid); end
        press_sw(4'b0100);
        n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid2 got %b want 1", in_valid); end
        n_cmp++; if (in_data !== 8'h4B) begin n_fail++; $display("FAIL hs_data2 got %h want 4b", in_data); end
    endtask

    task automatic test_simultaneous();
        // Pending with 0x4B; submit pulse coincides with ack.
        sw = 4'b0100;
        repeat (7) tick();
        n_cmp++; if (press !== 4'b0100) begin n_fail++; $display("FAIL sim_press got %b want 0100", press); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL sim_ack got %b want 0", in_valid); end
        repeat (3) tick();
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL sim_lost got %b want 0", in_valid); end
        n_cmp++; if (in_data !== 8'h4B) begin n_fail++; $display("FAIL sim_data got %h want 4b", in_data); end
        sw = 4'b0000;
        repeat (12) tick();
        press_sw(4'b1001);
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL sim_clear_wins got %h want 00", entry); end
        press_sw(4'b0011);
        n_cmp++; if (entry !== 8'h11) begin n_fail++; $display("FAIL sim_both_nibbles got %h want 11", entry); end
    endtask

    task automatic test_reset_mid();
        logic       exp_v;
        logic [3:0] exp_p;
        press_sw(4'b1000);
        repeat (5) press_sw(4'b0001);
        repeat (12) press_sw(4'b0010);
        n_cmp++; if (entry !== 8'h5C) begin n_fail++; $display("FAIL mid_entry got %h want 5c", entry); end
        press_sw(4'b0100);
        n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending got %b want 1", in_valid); end
        sw = 4'b0100;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL mid_rst_entry got %h want 00", entry); end
        n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h want 00", in_data); end
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", in_valid); end
        n_cmp++; if (press !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_press got %b want 0000", press); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_v = (k >= 8);
            exp_p = (k == 7) ? 4'b0100 : 4'b0000;
            n_cmp++; if (in_valid !== exp_v) begin n_fail++; $display("FAIL mid_valid k=%0d got %b want %b", k, in_valid, exp_v); end
            n_cmp++; if (press !== exp_p) begin n_fail++; $display("FAIL mid_press k=%0d got %b want %b", k, press, exp_p); end
        end
        n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", in_data); end
        sw = 4'b0000;
        repeat (12) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ack got %b want 0", in_valid); end
    endtask

    task automatic test_ack_idle();
        ack = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ack_valid k=%0d got %b want 0", k, in_valid); end
            n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL idle_ack_data k=%0d got %h want 00", k, in_data); end
        end
        ack = 1'b0;
        n_cmp++; if (entry !== 8'h00) begin n_fail++; $display("FAIL idle_ack_entry got %h want 00", entry); end
        press_sw(4'b0010);
        press_sw(4'b0100);
        n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL idle_then_submit got %b want 1", in_valid); end
        n_cmp++; if (in_data !== 8'h01) begin n_fail++; $display("FAIL idle_then_data got %h want 01", in_data); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        sw     = 4'b0000;
        ack    = 1'b0;
        test_reset();
        test_debounce();
        test_wrap();
        test_handshake();
        test_simultaneous();
        test_reset_mid();
        test_ack_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_byte_entry.md
# switch_byte_entry

Input-side counterpart to the CPU output display path on the Go Board. Debounces the four board push-switches, lets the operator compose an 8-bit value one nibble at a time, and presents a submitted byte to the CPU's input port through a valid/ack handshake. The current entry value is exported for the 7-segment display, so the operator sees what they are typing.

## Interface
- DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronized switch level must differ from its stable value before the stable value flips (10 ms at 25 MHz); must be ≥ 2.
- i_Clk  in  1  board clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Switch  in  4  raw switch levels, 1 = pressed; [0] high-nibble +1, [1] low-nibble +1, [2] submit, [3] clear entry.
- i_In_Ack  in  1  CPU consumed o_In_Data; single-cycle pulse or held level, both accepted.
- o_Entry  out  8  byte being composed (to display).
- o_In_Data  out  8  last submitted byte, stable while o_In_Valid high.
- o_In_Valid  out  1  submitted byte awaiting CPU ack.
- o_Press  out  4  one-cycle press pulses per switch (debug / LED use).

## Operation
- Per switch: 2-flop synchronizer (s1, s2), then debouncer with stable bit and counter sized clog2(DEBOUNCE_LIMIT).
- Debouncer: if s2 == stable, counter <= 0. Else counter increments; on the edge where counter == DEBOUNCE_LIMIT-1, stable <= s2 and counter <= 0. Glitches shorter than DEBOUNCE_LIMIT cycles never change stable.
- o_Press[n] is a registered pulse: high for exactly one cycle after stable[n] goes 0→1. Releases (1→0) produce no pulse.
- Entry actions, applied on the edge where o_Press is high:
  - Press[0]: o_Entry[7:4] +1 mod 16 (F→0, no carry into anything).
  - Press[1]: o_Entry[3:0] +1 mod 16 (F→0, no carry into high nibble).
  - Press[3]: o_Entry <= 0. Clear wins over Press[0]/[1] in the same cycle.
  - Press[2]: submit, handled by FSM.
- Handshake FSM, two states:
  - IDLE (o_In_Valid=0): Press[2] → o_In_Data <= o_Entry (value before any same-cycle edit), o_In_Valid <= 1, go PENDING. i_In_Ack ignored.
  - PENDING (o_In_Valid=1): i_In_Ack=1 → o_In_Valid <= 0, go IDLE. Press[2] ignored and discarded (not queued), including when it coincides with ack. o_In_Data frozen.
- Editing (Press[0],[1],[3]) is allowed in both states and never affects o_In_Data / o_In_Valid.

## Timing
- Reset (any cycle, including mid-debounce or PENDING): s1, s2, stable, counters, o_Press, o_Entry, o_In_Data, o_In_Valid all 0; FSM to IDLE.
- Switch held through reset deasserts is seen as a new press: Press pulse follows DEBOUNCE_LIMIT+3 cycles after reset release.
- Latency, raw rise held steady before edge E1: s2 new at E2; counter reaches limit, stable flips at E(DEBOUNCE_LIMIT+2); o_Press high after E(DEBOUNCE_LIMIT+3); o_Entry / o_In_Valid update at E(DEBOUNCE_LIMIT+4).
- o_In_Valid falls on the edge sampling i_In_Ack=1; earliest next submit accepted the following cycle.
- Two different switches stabilizing on the same edge: all pulses in one cycle, actions combined per the rules above.
- No combinational path from i_Switch or i_In_Ack to any output.

## Test plan
All with DEBOUNCE_LIMIT=4.
- Debounce/latency: after reset, raise i_Switch[1] and hold → o_Press[1] high exactly one cycle, 7 cycles after raise; o_Entry=0x01 at cycle 8; release → no pulse, no change. A 3-cycle high glitch on i_Switch[0] → no pulse, o_Entry unchanged.
- Wrap: 16 presses of i_Switch[0] from 0x00 → o_Entry steps 0x10..0xF0 then 0x00; 17 presses of i_Switch[1] from 0x00 → 0x01, low nibble only, high nibble stays 0.
- Handshake: entry 0x3A, press submit → o_In_Valid=1, o_In_Data=0x3A; edit entry to 0x4B and press submit again before ack → o_In_Data stays 0x3A; pulse i_In_Ack → o_In_Valid=0 next edge; submit → o_In_Data=0x4B.
- Simultaneous: in PENDING, submit press coincident with i_In_Ack → o_In_Valid=0, submit lost; clear coincident with increment → o_Entry=0x00.
- Reset mid-operation: in PENDING with o_Entry=0x5C and i_Switch[2] held, assert i_Reset one cycle → all outputs 0; after release, held switch submits 0x00 at DEBOUNCE_LIMIT+4 cycles.
- Ack in IDLE: drive i_In_Ack=1 for 5 cycles with no pending byte → o_In_Valid stays 0, no state change.
